// File: rtl/load_align_unit.sv
// load_align_unit: load-side alignment unit.
// Takes a byte address plus a RISC-V load funct3 and issues word-aligned
// reads to data memory. A halfword or word that straddles a word boundary
// is fetched with two reads. The addressed byte, halfword or word is then
// extracted, sign- or zero-extended, and returned as a one-cycle response.
// Only one request is in flight at any time.

module load_align_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] addr,
  input  logic [2:0]       funct3,
  output logic             mem_rd_en,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err
);

  // Control states.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RD0  = 2'b01;
  localparam logic [1:0] RD1  = 2'b10;
  localparam logic [1:0] DONE = 2'b11;

  // Increment between the first and second word of a split access.
  localparam logic [WIDTH-1:0] WORD_STEP = {{(WIDTH-3){1'b0}}, 3'b100};

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [1:0]       offset_r;
  logic [2:0]       funct3_r;
  logic [WIDTH-1:0] word0_r;
  logic [WIDTH-1:0] word1_r;

  logic             accept_s;
  logic             beat_s;
  logic             split_s;
  logic             legal_s;
  logic             enter_done_s;
  logic [WIDTH-1:0] word_lo_s;
  logic [WIDTH-1:0] word_hi_s;
  logic [WIDTH-1:0] result_s;

  // funct3 values that name a supported load.
  function automatic logic is_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // A load needs a second word when its bytes run past byte 3 of the first.
  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    logic sp;
    case (f3)
      3'b001, 3'b101: sp = (off == 2'b11);
      3'b010:         sp = (off != 2'b00);
      default:        sp = 1'b0;
    endcase
    return sp;
  endfunction

  // Shift the two-word window down to the addressed byte, then extend.
  function automatic logic [WIDTH-1:0] load_extend(
    input logic [2:0]       f3,
    input logic [1:0]       off,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi
  );
    logic [2*WIDTH-1:0] pair;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   res;
    pair = {hi, lo} >> {off, 3'b000};
    d    = pair[WIDTH-1:0];
    case (f3)
      3'b000:  res = {{(WIDTH-8){d[7]}}, d[7:0]};
      3'b100:  res = {{(WIDTH-8){1'b0}}, d[7:0]};
      3'b001:  res = {{(WIDTH-16){d[15]}}, d[15:0]};
      3'b101:  res = {{(WIDTH-16){1'b0}}, d[15:0]};
      3'b010:  res = d;
      default: res = {WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  // The unit only takes a new request while idle.
  always_comb begin
    req_ready = (state_r == IDLE);
  end

  // Handshake qualifiers. A read beat is never taken in the strobe cycle,
  // so data for the strobe just issued cannot be confused with older data.
  always_comb begin
    accept_s = req_valid && (state_r == IDLE);
    beat_s   = mem_rvalid && !mem_rd_en;
    legal_s  = is_legal(funct3);
    split_s  = is_split(funct3_r, offset_r);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (legal_s) begin
            state_nxt_s = RD0;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD0: begin
        if (beat_s) begin
          if (split_s) begin
            state_nxt_s = RD1;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = RD0;
        end
      end
      RD1: begin
        if (beat_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RD1;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Select the word pair feeding the extractor: the arriving beat fills in
  // whichever word is still missing, so the result is ready on entry to DONE.
  always_comb begin
    word_lo_s = word0_r;
    word_hi_s = word1_r;
    if (state_r == RD0) begin
      word_lo_s = mem_rdata;
      word_hi_s = {WIDTH{1'b0}};
    end else if (state_r == RD1) begin
      word_lo_s = word0_r;
      word_hi_s = mem_rdata;
    end else begin
      word_lo_s = word0_r;
      word_hi_s = word1_r;
    end
    result_s     = load_extend(funct3_r, offset_r, word_lo_s, word_hi_s);
    enter_done_s = (state_nxt_s == DONE) && (state_r != DONE);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the byte offset and load type of the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_r <= 2'b00;
      funct3_r <= 3'b000;
    end else if (accept_s) begin
      offset_r <= addr[1:0];
      funct3_r <= funct3;
    end else begin
      offset_r <= offset_r;
      funct3_r <= funct3_r;
    end
  end

  // Memory read strobe and word address; the strobe is a single-cycle pulse
  // and the address is held afterwards so the second beat can step from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= {WIDTH{1'b0}};
    end else if (accept_s && legal_s) begin
      mem_rd_en <= 1'b1;
      mem_addr  <= {addr[WIDTH-1:2], 2'b00};
    end else if ((state_r == RD0) && beat_s && split_s) begin
      mem_rd_en <= 1'b1;
      mem_addr  <= mem_addr + WORD_STEP;
    end else begin
      mem_rd_en <= 1'b0;
      mem_addr  <= mem_addr;
    end
  end

  // Capture the returned words; word1 is cleared per request so a
  // non-split access never sees a stale upper word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word0_r <= {WIDTH{1'b0}};
      word1_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      word0_r <= word0_r;
      word1_r <= {WIDTH{1'b0}};
    end else if ((state_r == RD0) && beat_s) begin
      word0_r <= mem_rdata;
      word1_r <= word1_r;
    end else if ((state_r == RD1) && beat_s) begin
      word0_r <= word0_r;
      word1_r <= mem_rdata;
    end else begin
      word0_r <= word0_r;
      word1_r <= word1_r;
    end
  end

  // Response: pulse resp_valid on entry to DONE and update data/error there;
  // data and error are held between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= {WIDTH{1'b0}};
      resp_err   <= 1'b0;
    end else if (enter_done_s && (state_r == IDLE)) begin
      resp_valid <= 1'b1;
      resp_data  <= {WIDTH{1'b0}};
      resp_err   <= 1'b1;
    end else if (enter_done_s) begin
      resp_valid <= 1'b1;
      resp_data  <= result_s;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_data  <= resp_data;
      resp_err   <= resp_err;
    end
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Load-side counterpart of the store-merge path. It accepts a load request (byte address plus RISC-V funct3) and issues word-aligned reads to the data memory/cache.
- It extracts, sign-extends or zero-extends the addressed byte, halfword or word and returns it to the writeback stage.
- Misaligned halfword and word loads that cross a word boundary are handled by a two-beat read sequence.

Parameters:
- WIDTH, 32, data and address width in bits. Only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  load request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- addr  input  WIDTH  byte address of the load
- funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- mem_rd_en  output  1  one-cycle read strobe to memory
- mem_addr  output  WIDTH  word-aligned read address; bits [1:0] are always 00
- mem_rdata  input  WIDTH  read data from memory
- mem_rvalid  input  1  mem_rdata is valid this cycle
- resp_valid  output  1  one-cycle pulse; resp_data and resp_err are valid
- resp_data  output  WIDTH  extended load result; held until the next response
- resp_err  output  1  illegal funct3 (011, 110, 111); held with resp_data

Behaviour:
- States: IDLE, RD0, RD1, DONE. All outputs are registered except req_ready = (state == IDLE).
- Reset (asynchronous, any state): state = IDLE; mem_rd_en = 0, mem_addr = 0, resp_valid = 0, resp_data = 0, resp_err = 0; captured words cleared. Any in-flight read is abandoned and its later mem_rvalid is ignored.
- IDLE, on req_valid && req_ready:
  - Latch addr and funct3.
  - Legal funct3: next state RD0; mem_rd_en = 1 and mem_addr = {addr[31:2], 2'b00} during the first RD0 cycle only.
  - Illegal funct3: next state DONE with resp_err = 1 and resp_data = 0; no memory read.
- RD0: mem_rvalid is ignored in the cycle mem_rd_en is high and sampled in every later RD0 cycle. On mem_rvalid, capture word0.
  - Split access when: lh/lhu with addr[1:0] == 11, or lw with addr[1:0] != 00.
  - Split: go to RD1; mem_rd_en = 1 for one cycle with mem_addr = word0 address + 4. The +4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - Not split: go to DONE.
- RD1: same mem_rvalid rule as RD0. On mem_rvalid, capture word1 and go to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then return to IDLE.
- Result computation, registered on entry to DONE:
  - Let D = {word1, word0} >> (8 * addr[1:0]); word1 = 0 when the access is not split.
  - lb: sign-extend D[7:0]. lbu: zero-extend D[7:0].
  - lh: sign-extend D[15:0]. lhu: zero-extend D[15:0].
  - lw: D[31:0].
- Latency, with memory asserting mem_rvalid the cycle after mem_rd_en; accept edge ends cycle 0:
  - aligned or non-split load: resp_valid in cycle 3
  - split load: resp_valid in cycle 5
  - illegal funct3: resp_valid in cycle 1
  - Extra memory wait cycles add 1:1.
- Throughput: one outstanding request. With req_valid held high, the next accept occurs in the IDLE cycle after DONE.
- mem_rvalid in IDLE or DONE is ignored and causes no state or output change.
- resp_data and resp_err keep their last values outside resp_valid cycles.

Test Plan:
Memory image for all scenarios: [0x100] = 0x8899AABB, [0x104] = 0x11223344; memory responds one cycle after mem_rd_en.
- lb @0x103 -> single read @0x100; resp_data 0xFFFFFF88, resp_err 0, resp_valid in cycle 3. Repeat with lbu -> 0x00000088.
- lh @0x102 -> 0xFFFF8899. lhu @0x101 -> 0x000099AA. lw @0x100 -> 0x8899AABB. Each issues exactly one mem_rd_en pulse.
- lw @0x102 -> two rd pulses at 0x100 then 0x104; resp_data 0x33448899, resp_valid in cycle 5. lh @0x103 -> 0x00004488.
- funct3 = 011 @0x100 -> no mem_rd_en; resp_valid in cycle 1 with resp_err 1 and resp_data 0. A following legal lb @0x100 -> resp_data 0xFFFFFFBB, resp_err 0.
- Assert rst during RD1 of lw @0x102 -> all outputs 0 and req_ready 1 immediately; a stray mem_rvalid two cycles later causes no resp_valid.
- Add 3 wait cycles before each mem_rvalid on lw @0x101 -> resp_data 0x448899AA. Hold req_valid high across two requests -> second accept in the cycle after resp_valid; no request is dropped or duplicated.
